// File: rtl/xnor_stream_checker.sv
// xnor_stream_checker: per-frame statistics over a stream of XNOR bit-pair equalities
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a frame (sampled only in IDLE)
//   in_valid   a/b carry a valid pair this cycle
//   a, b       stream bits under comparison
//   in_ready   pair accepted this cycle (RUN only)
//   eq         a XNOR b of the last accepted pair
//   match_cnt  accepted pairs with eq=1 in the current/last frame
//   err_cnt    accepted pairs with eq=0 in the current/last frame
//   run_len    current consecutive-match run, saturating
//   locked     sticky once run_len reaches LOCK_RUN within the frame
//   busy       state is RUN
//   done       one-cycle end-of-frame pulse (state is DONE)
module xnor_stream_checker #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4,
    parameter int LOCK_RUN  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    output logic             in_ready,
    output logic             eq,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] run_len,
    output logic             locked,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] idx;
    logic             match;
    logic [CNT_W-1:0] run_nxt;
    assign match    = a ~^ b;
    assign run_nxt  = !match ? '0 : (&run_len) ? run_len : run_len + CNT_W'(1);
    assign in_ready = state == RUN;
    assign busy     = state == RUN;
    assign done     = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            eq        <= 1'b0;
            match_cnt <= '0;
            err_cnt   <= '0;
            run_len   <= '0;
            locked    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state     <= RUN;
                    idx       <= '0;
                    eq        <= 1'b0;
                    match_cnt <= '0;
                    err_cnt   <= '0;
                    run_len   <= '0;
                    locked    <= 1'b0;
                end
                RUN: if (in_valid) begin
                    eq        <= match;
                    match_cnt <= match ? match_cnt + CNT_W'(1) : match_cnt;
                    err_cnt   <= match ? err_cnt : err_cnt + CNT_W'(1);
                    run_len   <= run_nxt;
                    // sticky: a later mismatch leaves locked set until the next frame
                    if (run_nxt >= CNT_W'(LOCK_RUN)) locked <= 1'b1;
                    idx       <= idx + CNT_W'(1);
                    if (idx == CNT_W'(FRAME_LEN - 1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/xnor_stream_checker.md
# xnor_stream_checker

Sequential consumer of the XNOR equality stage. Each cycle it accepts one bit pair (a, b) under a valid/ready handshake, forms the per-bit equality a XNOR b, and accumulates per-frame statistics: matches, mismatches, current run of consecutive matches, and a lock flag. A frame is FRAME_LEN accepted pairs. It is started by a one-cycle `start` and ends with a one-cycle `done` pulse.

## Interface
- FRAME_LEN, 8: accepted bit pairs per frame; legal range 1 to 2^CNT_W-1.
- CNT_W, 4: width of all counters; must satisfy 2^CNT_W-1 >= FRAME_LEN.
- LOCK_RUN, 4: consecutive matches needed to assert `locked`; legal range 1 to FRAME_LEN.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a frame; sampled only in IDLE.
- in_valid  in  1  a/b hold a valid pair this cycle.
- a  in  1  stream A bit.
- b  in  1  stream B bit.
- in_ready  out  1  block accepts a pair this cycle; 1 only in RUN.
- eq  out  1  registered a XNOR b of the last accepted pair.
- match_cnt  out  CNT_W  accepted pairs with eq=1 in the current/last frame.
- err_cnt  out  CNT_W  accepted pairs with eq=0 in the current/last frame.
- run_len  out  CNT_W  current consecutive-match run; saturates at 2^CNT_W-1.
- locked  out  1  set when run_len reaches LOCK_RUN; sticky until frame clear or reset.
- busy  out  1  state is RUN.
- done  out  1  one-cycle pulse; state is DONE.

## Operation
- Reset: state IDLE. eq, match_cnt, err_cnt, run_len, locked, busy, done and in_ready are all 0. Internal bit index is 0.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE: in_ready=0. If start=1, go to RUN. On the same edge, clear eq, match_cnt, err_cnt, run_len, locked and the bit index. Without start, all counters hold the last frame's results.
- RUN: in_ready=1. A pair is accepted when in_valid=1. On acceptance:
  - eq <= a XNOR b.
  - If equal: match_cnt+1, and run_len+1 (saturating).
  - If not equal: err_cnt+1, and run_len <= 0.
  - locked <= 1 when the new run_len is >= LOCK_RUN. A later mismatch does not clear it.
  - The bit index increments.
  - On the FRAME_LEN-th accepted pair, go to DONE.
- When in_valid=0 in RUN, all state holds.
- `start` is ignored in RUN and DONE.
- DONE: done=1, in_ready=0. Counters hold. Unconditionally go to IDLE next cycle.
- Invariant at done: match_cnt + err_cnt = FRAME_LEN.
- Reset asserted mid-frame: immediate return to reset values. No partial results are kept.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- in_ready and busy are decoded from the state register.
- Latency: eq and the counters reflect an accepted pair in the cycle after the accepting edge.
- Frame length: with in_valid held high, the frame occupies FRAME_LEN cycles in RUN. done is high in cycle FRAME_LEN+1 after the start edge.
- Minimum start-to-start period: FRAME_LEN+2 cycles (RUN, then DONE, then IDLE sampling start).
- A start asserted during the DONE cycle is lost. A start in the following IDLE cycle is honoured.
- rst_n is asynchronous on assertion. Deassertion is assumed synchronous to clk externally.

## Test plan
- Reset: hold rst_n=0 mid-activity, then release. Required: all outputs 0, in_ready=0, state IDLE.
- All-match frame (default parameters): start, then 8 pairs with a=b and in_valid=1. Required:
  - match_cnt=8, err_cnt=0, run_len=8.
  - locked rises in the cycle after the 4th accepted pair.
  - done is a single pulse in cycle 9 after start.
- XNOR truth table: send the pairs (0,0), (0,1), (1,0), (1,1), twice. Required:
  - eq sequence 1,0,0,1,1,0,0,1.
  - match_cnt=4, err_cnt=4, final run_len=1, locked=0.
- Handshake gaps: in_valid toggles 1,0 for 16 cycles carrying 8 equal pairs. Required:
  - Counters advance only on valid cycles.
  - done after the 8th accepted pair, not before.
  - Counters hold during gaps.
- Lock boundary: pattern match×3, mismatch, match×4. Required:
  - run_len goes 1,2,3,0,1,2,3,4.
  - locked is 0 until after the 8th accepted pair, then 1.
  - match_cnt=7, err_cnt=1.
- Abort and ignored start:
  - start pulses during RUN have no effect.
  - rst_n=0 after 3 accepted pairs clears everything.
  - A new start then runs a clean 8-pair frame with correct counts.
  - start during DONE is ignored, and counters hold in IDLE.
